// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and post-reset zero-initialisation walk.
// Latency: reads combinational with same-cycle write bypass; busy_cnt/init_done registered.
// Backpressure: none; every write and mark is accepted once the walk has finished.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   addA/addB          read addresses -> dataA/dataB, busyA/busyB (combinational)
//   addD/WB_out        write address/data, RegWrite enables and clears busy[addD]
//   mark_en/mark_addr  set busy[mark_addr] (mark wins over a same-cycle write)
//   busy_cnt           number of busy registers, init_done high after the walk
module regfile_sb #(
   parameter int  XLEN     = 32,
   parameter int  NREGS    = 32,
   parameter bit  ZERO_REG = 1'b1,
   localparam int AW       = $clog2(NREGS),
   localparam int CW       = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   addA,
   input  logic [AW-1:0]   addB,
   output logic [XLEN-1:0] dataA,
   output logic [XLEN-1:0] dataB,
   output logic            busyA,
   output logic            busyB,
   input  logic [AW-1:0]   addD,
   input  logic [XLEN-1:0] WB_out,
   input  logic            RegWrite,
   input  logic            mark_en,
   input  logic [AW-1:0]   mark_addr,
   output logic [CW-1:0]   busy_cnt,
   output logic            init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              init_done_q;
   logic [XLEN-1:0]   regs [NREGS];

   logic              run;
   logic              wr_eff;
   logic              mk_eff;
   logic              cnt_inc;
   logic              cnt_dec;

   assign run    = (state_q == ST_RUN);
   assign wr_eff = run && RegWrite && !(ZERO_REG && addD == '0);
   assign mk_eff = run && mark_en  && !(ZERO_REG && mark_addr == '0);

   // Walk sequencing: one register zeroed per cycle, RUN after the last index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_INIT: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Scoreboard update; the mark is applied last so it wins on a shared address.
   always_comb begin
      busy_d = busy_q;
      if (wr_eff) begin
         busy_d[addD] = 1'b0;
      end
      if (mk_eff) begin
         busy_d[mark_addr] = 1'b1;
      end
   end

   // Counter tracks popcount incrementally: a mark only counts on a free register,
   // a write only retires a busy one, and a same-address mark cancels the retire.
   assign cnt_inc = mk_eff && !busy_q[mark_addr];
   assign cnt_dec = wr_eff && busy_q[addD] && !(mk_eff && mark_addr == addD);
   assign cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         busy_q      <= '0;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         init_done_q <= run;
      end
   end

   // Storage is not reset; the walk provides the zero contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_INIT) begin
            regs[idx_q] <= '0;
         end else if (wr_eff) begin
            regs[addD] <= WB_out;
         end
      end
   end

   always_comb begin
      dataA = '0;
      busyA = 1'b0;
      if (run && !(ZERO_REG && addA == '0)) begin
         if (wr_eff && addD == addA) begin
            dataA = WB_out;
         end else begin
            dataA = regs[addA];
            busyA = busy_q[addA];
         end
      end
   end

   always_comb begin
      dataB = '0;
      busyB = 1'b0;
      if (run && !(ZERO_REG && addB == '0)) begin
         if (wr_eff && addD == addB) begin
            dataB = WB_out;
         end else begin
            dataB = regs[addB];
            busyB = busy_q[addB];
         end
      end
   end

   assign busy_cnt  = cnt_q;
   assign init_done = init_done_q;

endmodule
